// File: rtl/lock_button_conditioner.sv
// Button conditioner feeding the combination lock: synchronises and debounces two raw
// push-buttons, then arbitrates their rising edges into exclusive one-cycle pulses.

module lock_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise_c
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (s2 == lvl) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            lvl <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise_c = lvl & ~lvl_d;

endmodule

module lock_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_zero,
    input  logic btn_one,
    output logic zero,
    output logic one,
    output logic conflict,
    output logic zero_lvl,
    output logic one_lvl
);
    logic rise_zero;
    logic rise_one;
    logic zero_next;
    logic one_next;
    logic conflict_next;

    lock_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_zero (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn_zero),
        .lvl    (zero_lvl),
        .rise_c (rise_zero)
    );

    lock_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_one (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn_one),
        .lvl    (one_lvl),
        .rise_c (rise_one)
    );

    // A press is accepted only while the other button is fully released
    always_comb begin
        zero_next     = 1'b0;
        one_next      = 1'b0;
        conflict_next = 1'b0;
        if (rise_zero && !rise_one && !one_lvl) begin
            zero_next = 1'b1;
        end else if (rise_one && !rise_zero && !zero_lvl) begin
            one_next = 1'b1;
        end else if (rise_zero || rise_one) begin
            conflict_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero     <= 1'b0;
            one      <= 1'b0;
            conflict <= 1'b0;
        end else begin
            zero     <= zero_next;
            one      <= one_next;
            conflict <= conflict_next;
        end
    end

endmodule
